// File: rtl/vend_controller.sv
// Vending-machine control FSM: tracks the inserted total, decides vends and
// computes change for the text overlay and the dispensing mechanism.
module vend_controller #(
   parameter int unsigned PRICE0      = 25,
   parameter int unsigned PRICE1      = 50,
   parameter int unsigned PRICE2      = 75,
   parameter int unsigned PRICE3      = 90,
   parameter int unsigned MAX_TOTAL   = 95,
   parameter int unsigned VEND_CYCLES = 25_000_000,
   parameter int unsigned HOLD_CYCLES = 75_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       select_valid,
   input  logic [1:0] item_sel,
   input  logic       cancel,
   output logic [1:0] state,
   output logic [7:0] total,
   output logic [7:0] change,
   output logic [1:0] selected_item,
   output logic       show_text,
   output logic       dispense,
   output logic       change_return,
   output logic       coin_reject,
   output logic       select_denied
);

   localparam int unsigned MaxCycles = (VEND_CYCLES > HOLD_CYCLES) ? VEND_CYCLES : HOLD_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [CntW-1:0] VendLast = CntW'(VEND_CYCLES - 1);
   localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StCollect = 2'b01,
      StChange  = 2'b10,
      StVend    = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      total_q, total_d;
   logic [7:0]      change_q, change_d;
   logic [1:0]      item_q, item_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            show_q, show_d;
   logic            disp_q, disp_d;
   logic            cret_q, cret_d;
   logic            rej_q, rej_d;
   logic            den_q, den_d;

   logic [7:0] coin_value;
   logic       coin_ok;
   logic [7:0] price;
   logic [8:0] sum;

   always_comb begin
      coin_ok = 1'b1;
      case (coin_type)
         2'b00:   coin_value = 8'd5;
         2'b01:   coin_value = 8'd10;
         2'b10:   coin_value = 8'd25;
         default: begin
            coin_value = 8'd0;
            coin_ok    = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (item_sel)
         2'b00:   price = 8'(PRICE0);
         2'b01:   price = 8'(PRICE1);
         2'b10:   price = 8'(PRICE2);
         default: price = 8'(PRICE3);
      endcase
   end

   // Widened so an overflowing sum can never wrap below MAX_TOTAL.
   assign sum = {1'b0, total_q} + {1'b0, coin_value};

   always_comb begin
      state_d  = state_q;
      total_d  = total_q;
      change_d = change_q;
      item_d   = item_q;
      cnt_d    = cnt_q + CntW'(1);
      disp_d   = 1'b0;
      cret_d   = 1'b0;
      rej_d    = 1'b0;
      den_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (coin_valid) begin
               if (coin_ok) begin
                  total_d = coin_value;
                  state_d = StCollect;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         StCollect: begin
            if (cancel) begin
               change_d = total_q;
               total_d  = 8'd0;
               state_d  = StChange;
               cret_d   = (total_q != 8'd0);
               rej_d    = coin_valid;
            end else if (select_valid && (total_q >= price)) begin
               change_d = total_q - price;
               total_d  = 8'd0;
               item_d   = item_sel;
               state_d  = StVend;
               disp_d   = 1'b1;
               rej_d    = coin_valid;
            end else begin
               den_d = select_valid;
               if (coin_valid) begin
                  if (coin_ok && (sum <= 9'(MAX_TOTAL))) begin
                     total_d = sum[7:0];
                  end else begin
                     rej_d = 1'b1;
                  end
               end
            end
         end
         StVend: begin
            rej_d = coin_valid;
            if (cnt_q == VendLast) begin
               state_d = StChange;
               cret_d  = (change_q != 8'd0);
            end
         end
         StChange: begin
            rej_d = coin_valid;
            if (cnt_q == HoldLast) begin
               state_d  = StIdle;
               change_d = 8'd0;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end
      show_d = (state_d != StVend);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         total_q  <= 8'd0;
         change_q <= 8'd0;
         item_q   <= 2'd0;
         cnt_q    <= '0;
         show_q   <= 1'b1;
         disp_q   <= 1'b0;
         cret_q   <= 1'b0;
         rej_q    <= 1'b0;
         den_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         total_q  <= total_d;
         change_q <= change_d;
         item_q   <= item_d;
         cnt_q    <= cnt_d;
         show_q   <= show_d;
         disp_q   <= disp_d;
         cret_q   <= cret_d;
         rej_q    <= rej_d;
         den_q    <= den_d;
      end
   end

   assign state         = state_q;
   assign total         = total_q;
   assign change        = change_q;
   assign selected_item = item_q;
   assign show_text     = show_q;
   assign dispense      = disp_q;
   assign change_return = cret_q;
   assign coin_reject   = rej_q;
   assign select_denied = den_q;

endmodule
